// File: rtl/stupid_toy_load_arbiter.sv
// stupid_toy_load_arbiter: round-robin arbiter feeding one byte loader, with a post-load loader reset hold.
// Ports: clk, reset (sync, active-high); req/req_data per-requester level requests and bytes;
// ack one-hot grant pulse; loader_data/loader_load_enable/loader_reset drive the loader;
// grant_id last granted index; busy high outside IDLE.
// Optional macro STUPID_TOY_LOAD_ARB_COUNT_EN adds load_count, a 16-bit wrapping strobe counter.
module stupid_toy_load_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [7:0]                 loader_data,
  output logic                       loader_load_enable,
  output logic                       loader_reset,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
`ifdef STUPID_TOY_LOAD_ARB_COUNT_EN
  ,
  output logic [15:0]                load_count
`endif
);
  localparam int W = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, LOAD, CLEAR} state_t;
  state_t           state_q, state_d;
  logic [W-1:0]     ptr_q, ptr_d, gid_q, gid_d, win;
  logic [3:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0]       data_q, data_d;
  logic             lle_q, lle_d;
  int               idx;
  always_comb begin
    win = '0;
    idx = 0;
    // Scan downward in offset so the smallest offset from ptr wins last.
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (req[idx]) win = W'(idx);
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    lle_d   = 1'b0;
    data_d  = data_q;
    gid_d   = gid_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = LOAD;
        ptr_d   = W'((int'(win) + 1) % N_REQ);
        ack_d   = N_REQ'(1) << win;
        lle_d   = 1'b1;
        data_d  = req_data[8*win +: 8];
        gid_d   = win;
      end
      LOAD: begin
        state_d = CLEAR;
        cnt_d   = 4'(HOLD_CYCLES - 1);
      end
      CLEAR: begin
        state_d = cnt_q == 4'd0 ? IDLE : CLEAR;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      lle_q   <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      lle_q   <= lle_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end
  // Reset during the LOAD cycle suppresses the in-flight ack and strobe immediately.
  assign ack                = ack_q & {N_REQ{~reset}};
  assign loader_load_enable = lle_q & ~reset;
  assign loader_data        = data_q;
  assign grant_id           = gid_q;
  assign loader_reset       = reset | (state_q == CLEAR);
  assign busy               = state_q != IDLE;
`ifdef STUPID_TOY_LOAD_ARB_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_q + 16'(loader_load_enable);
  end
  assign load_count = count_q;
`endif
endmodule
